// File: rtl/index_lookup_pkg.sv
// -----------------------------------------------------------------------------
// index_lookup_pkg
//
// Shared constants and types for the index-to-DDR-address lookup arbiter.
//   IDX_W        width of the ROM address (lookup index)
//   ADDR_W       width of the ROM data (DDR row/word address)
//   LIMIT_INDEX  first index whose table entry is the saturation value
//   SAT_ADDR     the saturation value stored for out-of-range indices
//   tag_t        in-flight lookup tag carried alongside the ROM latency
// -----------------------------------------------------------------------------
package index_lookup_pkg;

    localparam int IDX_W       = 10;
    localparam int ADDR_W      = 12;
    localparam int LIMIT_INDEX = 680;

    localparam logic [ADDR_W-1:0] SAT_ADDR = 12'hFF0;

    // Requester identifiers used in the tag.
    localparam logic PORT_GBE = 1'b0;
    localparam logic PORT_LCD = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
        logic oor;
    } tag_t;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, port: PORT_GBE, oor: 1'b0};

endpackage : index_lookup_pkg

// File: rtl/index_lookup_rr2.sv
// -----------------------------------------------------------------------------
// index_lookup_rr2
//
// Two-way round-robin arbiter. When both requesters are active, the port that
// was not granted most recently wins. The last-grant pointer resets to port 1
// so that port 0 wins the first tie.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   req      in   [1:0] request vector (bit n = port n)
//   accept   in   the current grant is being taken this cycle
//   grant    out  [1:0] one-hot grant (zero when no request)
// -----------------------------------------------------------------------------
module index_lookup_rr2
    import index_lookup_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant_q == PORT_LCD) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // The pointer only moves on a real handshake; a grant offered while
    // arbitration is blocked (clear, reset release) does not count.
    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = grant[1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= PORT_LCD;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule : index_lookup_rr2

// File: rtl/index_lookup_arbiter.sv
// -----------------------------------------------------------------------------
// index_lookup_arbiter
//
// Shares the single-port index-to-DDR-address pROM between the GbE write path
// (port 0) and the LCD read path (port 1). One lookup is accepted per cycle
// under round-robin priority; its tag follows the ROM through a two-stage
// pipeline so the result is returned to the originating port, 3 cycles after
// the handshake, together with an out-of-range flag.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   clear                      synchronous flush of in-flight lookups
//   pN_req_valid/ready/index   request handshake for port N
//   pN_resp_valid/addr/oor     one-cycle result strobe, held address, range flag
//   rom_ad, rom_ce, rom_oce    pROM address / clock enable / output enable
//   rom_reset                  pROM synchronous reset (active high)
//   rom_dout                   pROM read data
// -----------------------------------------------------------------------------
module index_lookup_arbiter
    import index_lookup_pkg::*;
#(
    parameter int IDX_W       = index_lookup_pkg::IDX_W,
    parameter int ADDR_W      = index_lookup_pkg::ADDR_W,
    parameter int LIMIT_INDEX = index_lookup_pkg::LIMIT_INDEX
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,

    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic [IDX_W-1:0]  p0_req_index,
    output logic              p0_resp_valid,
    output logic [ADDR_W-1:0] p0_resp_addr,
    output logic              p0_resp_oor,

    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic [IDX_W-1:0]  p1_req_index,
    output logic              p1_resp_valid,
    output logic [ADDR_W-1:0] p1_resp_addr,
    output logic              p1_resp_oor,

    output logic [IDX_W-1:0]  rom_ad,
    output logic              rom_ce,
    output logic              rom_oce,
    output logic              rom_reset,
    input  logic [ADDR_W-1:0] rom_dout
);

    localparam logic [31:0] LIMIT_U = 32'(LIMIT_INDEX);

    // ROM reset is held for one extra cycle after reset_n rises so the pROM
    // sees a clean synchronous release; no lookups are taken in that cycle.
    logic rst_hold_q;
    logic rst_hold_d;

    logic              rom_ce_q;
    logic              rom_ce_d;
    logic [IDX_W-1:0]  rom_ad_q;
    logic [IDX_W-1:0]  rom_ad_d;

    // tag1 lines up with rom_ce/rom_ad, tag2 lines up with rom_dout.
    tag_t tag1_q;
    tag_t tag1_d;
    tag_t tag2_q;
    tag_t tag2_d;

    logic              p0_resp_valid_q;
    logic              p0_resp_valid_d;
    logic [ADDR_W-1:0] p0_resp_addr_q;
    logic [ADDR_W-1:0] p0_resp_addr_d;
    logic              p0_resp_oor_q;
    logic              p0_resp_oor_d;

    logic              p1_resp_valid_q;
    logic              p1_resp_valid_d;
    logic [ADDR_W-1:0] p1_resp_addr_q;
    logic [ADDR_W-1:0] p1_resp_addr_d;
    logic              p1_resp_oor_q;
    logic              p1_resp_oor_d;

    logic [1:0]        req;
    logic [1:0]        grant;
    logic              arb_en;
    logic              accept;
    logic [IDX_W-1:0]  sel_index;
    logic              sel_oor;
    logic              resp_fire;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    assign req    = {p1_req_valid, p0_req_valid};
    assign arb_en = !clear && !rst_hold_q;
    assign accept = arb_en && (req != 2'b00);

    index_lookup_rr2 u_rr2 (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .accept  (accept),
        .grant   (grant)
    );

    assign p0_req_ready = arb_en && grant[0];
    assign p1_req_ready = arb_en && grant[1];

    assign sel_index = grant[1] ? p1_req_index : p0_req_index;
    assign sel_oor   = ({{(32-IDX_W){1'b0}}, sel_index} >= LIMIT_U);

    // -------------------------------------------------------------------------
    // ROM drive and tag pipeline
    // -------------------------------------------------------------------------
    always_comb begin
        rst_hold_d = 1'b0;

        rom_ce_d = accept;
        rom_ad_d = rom_ad_q;
        if (accept) begin
            rom_ad_d = sel_index;
        end

        tag1_d       = TAG_IDLE;
        tag1_d.valid = accept;
        tag1_d.port  = grant[1];
        tag1_d.oor   = sel_oor;

        tag2_d = tag1_q;
        if (clear) begin
            tag2_d.valid = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Response capture
    // -------------------------------------------------------------------------
    // A tag already sitting at the ROM output is dropped too when clear is
    // high, so every lookup accepted before the flush is silent.
    assign resp_fire = tag2_q.valid && !clear;

    always_comb begin
        p0_resp_valid_d = resp_fire && (tag2_q.port == PORT_GBE);
        p1_resp_valid_d = resp_fire && (tag2_q.port == PORT_LCD);

        p0_resp_addr_d = p0_resp_addr_q;
        p0_resp_oor_d  = p0_resp_oor_q;
        if (p0_resp_valid_d) begin
            p0_resp_addr_d = rom_dout;
            p0_resp_oor_d  = tag2_q.oor;
        end

        p1_resp_addr_d = p1_resp_addr_q;
        p1_resp_oor_d  = p1_resp_oor_q;
        if (p1_resp_valid_d) begin
            p1_resp_addr_d = rom_dout;
            p1_resp_oor_d  = tag2_q.oor;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_hold_q      <= 1'b1;
            rom_ce_q        <= 1'b0;
            rom_ad_q        <= '0;
            tag1_q          <= TAG_IDLE;
            tag2_q          <= TAG_IDLE;
            p0_resp_valid_q <= 1'b0;
            p0_resp_addr_q  <= '0;
            p0_resp_oor_q   <= 1'b0;
            p1_resp_valid_q <= 1'b0;
            p1_resp_addr_q  <= '0;
            p1_resp_oor_q   <= 1'b0;
        end else begin
            rst_hold_q      <= rst_hold_d;
            rom_ce_q        <= rom_ce_d;
            rom_ad_q        <= rom_ad_d;
            tag1_q          <= tag1_d;
            tag2_q          <= tag2_d;
            p0_resp_valid_q <= p0_resp_valid_d;
            p0_resp_addr_q  <= p0_resp_addr_d;
            p0_resp_oor_q   <= p0_resp_oor_d;
            p1_resp_valid_q <= p1_resp_valid_d;
            p1_resp_addr_q  <= p1_resp_addr_d;
            p1_resp_oor_q   <= p1_resp_oor_d;
        end
    end

    assign rom_ce    = rom_ce_q;
    assign rom_ad    = rom_ad_q;
    assign rom_oce   = 1'b1;
    assign rom_reset = rst_hold_q;

    assign p0_resp_valid = p0_resp_valid_q;
    assign p0_resp_addr  = p0_resp_addr_q;
    assign p0_resp_oor   = p0_resp_oor_q;
    assign p1_resp_valid = p1_resp_valid_q;
    assign p1_resp_addr  = p1_resp_addr_q;
    assign p1_resp_oor   = p1_resp_oor_q;

endmodule : index_lookup_arbiter

// File: tb/tb_index_lookup_arbiter.sv
// -----------------------------------------------------------------------------
// tb_index_lookup_arbiter
//
// Bench for index_lookup_arbiter with a behavioural pROM (index*6, saturating
// at 0xFF0 from index 680) and a queue-based reference of accepted lookups.
// -----------------------------------------------------------------------------
module tb_index_lookup_arbiter;

    logic        clk;
    logic        reset_n;
    logic        clear;
    logic        p0_req_valid, p1_req_valid;
    logic        p0_req_ready, p1_req_ready;
    logic [9:0]  p0_req_index, p1_req_index;
    logic        p0_resp_valid, p1_resp_valid;
    logic [11:0] p0_resp_addr, p1_resp_addr;
    logic        p0_resp_oor, p1_resp_oor;
    logic [9:0]  rom_ad;
    logic        rom_ce, rom_oce, rom_reset;
    logic [11:0] rom_dout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int resp_seen = 0;

    index_lookup_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear         (clear),
        .p0_req_valid  (p0_req_valid),
        .p0_req_ready  (p0_req_ready),
        .p0_req_index  (p0_req_index),
        .p0_resp_valid (p0_resp_valid),
        .p0_resp_addr  (p0_resp_addr),
        .p0_resp_oor   (p0_resp_oor),
        .p1_req_valid  (p1_req_valid),
        .p1_req_ready  (p1_req_ready),
        .p1_req_index  (p1_req_index),
        .p1_resp_valid (p1_resp_valid),
        .p1_resp_addr  (p1_resp_addr),
        .p1_resp_oor   (p1_resp_oor),
        .rom_ad        (rom_ad),
        .rom_ce        (rom_ce),
        .rom_oce       (rom_oce),
        .rom_reset     (rom_reset),
        .rom_dout      (rom_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] lut(input logic [9:0] idx);
        if (int'(idx) >= 680) return 12'hFF0;
        return 12'(int'(idx) * 6);
    endfunction

    // pROM: registered read, synchronous reset.
    always @(posedge clk) begin
        if (rom_reset)   rom_dout <= 12'h000;
        else if (rom_ce) rom_dout <= lut(rom_ad);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference: expected lookups as a time-stamped queue.
    // ------------------------------------------------------------------
    typedef struct {
        logic        port;
        logic [11:0] addr;
        logic        oor;
        int          due;
    } exp_t;

    exp_t        q[$];
    logic        m_last       = 1'b1;
    logic        prev_rst_low = 1'b1;
    logic        prev_acc     = 1'b0;
    logic [9:0]  exp_ad       = '0;
    logic [11:0] exp_addr0    = '0, exp_addr1 = '0;
    logic        exp_oor0     = 1'b0, exp_oor1 = 1'b0;

    always @(negedge clk) begin
        logic [1:0] e_v;
        logic [1:0] want;
        logic [1:0] exp_g;
        logic [9:0] idx;
        exp_t       e;
        if (!reset_n) begin
            chk("rst_ready", 32'({p1_req_ready, p0_req_ready}), 32'd0);
            chk("rst_resp_valid", 32'({p1_resp_valid, p0_resp_valid}), 32'd0);
            chk("rst_addr0", 32'(p0_resp_addr), 32'd0);
            chk("rst_addr1", 32'(p1_resp_addr), 32'd0);
            chk("rst_oor", 32'({p1_resp_oor, p0_resp_oor}), 32'd0);
            chk("rst_rom_ce", 32'(rom_ce), 32'd0);
            chk("rst_rom_ad", 32'(rom_ad), 32'd0);
            chk("rst_rom_reset", 32'(rom_reset), 32'd1);
            chk("rst_rom_oce", 32'(rom_oce), 32'd1);
            q.delete();
            m_last = 1'b1; prev_rst_low = 1'b1; prev_acc = 1'b0; exp_ad = '0;
            exp_addr0 = '0; exp_addr1 = '0; exp_oor0 = 1'b0; exp_oor1 = 1'b0;
        end else begin
            chk("rom_reset", 32'(rom_reset), 32'(prev_rst_low));
            chk("rom_oce", 32'(rom_oce), 32'd1);
            chk("rom_ce", 32'(rom_ce), 32'(prev_acc));
            chk("rom_ad", 32'(rom_ad), 32'(exp_ad));

            e_v = 2'b00;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                e_v[e.port] = 1'b1;
                if (e.port) begin exp_addr1 = e.addr; exp_oor1 = e.oor; end
                else        begin exp_addr0 = e.addr; exp_oor0 = e.oor; end
            end
            chk("resp_valid", 32'({p1_resp_valid, p0_resp_valid}), 32'(e_v));
            chk("resp_addr0", 32'(p0_resp_addr), 32'(exp_addr0));
            chk("resp_addr1", 32'(p1_resp_addr), 32'(exp_addr1));
            chk("resp_oor", 32'({p1_resp_oor, p0_resp_oor}), 32'({exp_oor1, exp_oor0}));
            if (p0_resp_valid || p1_resp_valid) resp_seen++;

            want  = {p1_req_valid, p0_req_valid};
            exp_g = 2'b00;
            if (!clear && !prev_rst_low && want != 2'b00) begin
                if (want == 2'b11) exp_g = m_last ? 2'b01 : 2'b10;
                else               exp_g = want;
            end
            chk("req_ready", 32'({p1_req_ready, p0_req_ready}), 32'(exp_g));

            // Everything still in flight at a clear is lost.
            if (clear) q.delete();

            if (exp_g != 2'b00) begin
                idx = exp_g[1] ? p1_req_index : p0_req_index;
                q.push_back('{port: exp_g[1], addr: lut(idx), oor: (int'(idx) >= 680), due: cyc + 3});
                m_last   = exp_g[1];
                exp_ad   = idx;
                prev_acc = 1'b1;
            end else begin
                prev_acc = 1'b0;
            end
            prev_rst_low = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request, waits for the handshake, returns 1 cycle after it.
    task automatic do_req(input int port, input logic [9:0] idx);
        int n;
        if (port == 1) begin p1_req_valid = 1'b1; p1_req_index = idx; end
        else           begin p0_req_valid = 1'b1; p0_req_index = idx; end
        n = 0;
        #1;
        while (!((port == 1) ? p1_req_ready : p0_req_ready) && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL handshake_timeout: port %0d got no ready want ready within 20 cycles", port);
        end
        @(posedge clk);
        #1;
        if (port == 1) p1_req_valid = 1'b0;
        else           p0_req_valid = 1'b0;
    endtask

    initial begin
        int s;
        reset_n = 1'b0; clear = 1'b0;
        p0_req_valid = 1'b0; p1_req_valid = 1'b0;
        p0_req_index = '0;   p1_req_index = '0;

        // Reset release and first lookup.
        repeat (3) tick();
        chk("lit_rom_reset_in_reset", 32'(rom_reset), 32'd1);
        reset_n = 1'b1;
        p0_req_valid = 1'b1; p0_req_index = 10'd5;
        #1;
        chk("lit_ready_release_cycle", 32'(p0_req_ready), 32'd0);
        chk("lit_rom_reset_release_cycle", 32'(rom_reset), 32'd1);
        do_req(0, 10'd5);
        tick(); tick();
        chk("lit_p0_valid_idx5", 32'(p0_resp_valid), 32'd1);
        chk("lit_p0_addr_idx5", 32'(p0_resp_addr), 32'h01E);
        chk("lit_p0_oor_idx5", 32'(p0_resp_oor), 32'd0);
        chk("lit_p1_quiet_idx5", 32'(p1_resp_valid), 32'd0);

        // Reset asserted one cycle after an accept.
        do_req(0, 10'd7);
        reset_n = 1'b0;
        s = resp_seen;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (6) tick();
        chk("lit_no_resp_after_reset", 32'(resp_seen), 32'(s));
        chk("lit_addr0_reset_value", 32'(p0_resp_addr), 32'd0);

        // Continuous tie: grants alternate starting with port 0.
        p0_req_valid = 1'b1; p0_req_index = 10'd1;
        p1_req_valid = 1'b1; p1_req_index = 10'd2;
        #1;
        chk("lit_tie_first", 32'({p1_req_ready, p0_req_ready}), 32'b01);
        tick();
        chk("lit_tie_second", 32'({p1_req_ready, p0_req_ready}), 32'b10);
        tick();
        chk("lit_tie_third", 32'({p1_req_ready, p0_req_ready}), 32'b01);
        repeat (4) tick();
        p0_req_valid = 1'b0; p1_req_valid = 1'b0;
        repeat (5) tick();
        chk("lit_tie_addr0", 32'(p0_resp_addr), 32'h006);
        chk("lit_tie_addr1", 32'(p1_resp_addr), 32'h00C);

        // Range boundary.
        do_req(1, 10'h2A7);
        tick(); tick();
        chk("lit_p1_addr_2a7", 32'(p1_resp_addr), 32'hFEA);
        chk("lit_p1_oor_2a7", 32'(p1_resp_oor), 32'd0);
        do_req(1, 10'h2A8);
        tick(); tick();
        chk("lit_p1_valid_2a8", 32'(p1_resp_valid), 32'd1);
        chk("lit_p1_addr_2a8", 32'(p1_resp_addr), 32'hFF0);
        chk("lit_p1_oor_2a8", 32'(p1_resp_oor), 32'd1);

        // Clear one cycle after an accept.
        do_req(0, 10'd16);
        clear = 1'b1;
        s = resp_seen;
        tick();
        clear = 1'b0;
        repeat (5) tick();
        chk("lit_no_resp_after_clear", 32'(resp_seen), 32'(s));
        do_req(0, 10'd32);
        tick(); tick();
        chk("lit_p0_valid_idx32", 32'(p0_resp_valid), 32'd1);
        chk("lit_p0_addr_idx32", 32'(p0_resp_addr), 32'h0C0);

        // Random back-to-back traffic with occasional flushes.
        repeat (300) begin
            p0_req_valid = ($urandom_range(0, 3) != 0);
            p1_req_valid = ($urandom_range(0, 3) != 0);
            p0_req_index = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(670, 690))
                                                        : 10'($urandom_range(0, 1023));
            p1_req_index = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(670, 690))
                                                        : 10'($urandom_range(0, 1023));
            clear = ($urandom_range(0, 15) == 0);
            tick();
        end
        p0_req_valid = 1'b0; p1_req_valid = 1'b0; clear = 1'b0;
        repeat (6) tick();
        chk("lit_queue_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got no end want end before 200us");
        $fatal(1, "watchdog");
    end

endmodule : tb_index_lookup_arbiter

// File: doc/index_lookup_arbiter.md
# index_lookup_arbiter

Shares the single-port index-to-DDR-address ROM (10-bit index in, 12-bit DDR row/word address out, one registered read cycle) between two requesters: the GbE write path (port 0) and the LCD read path (port 1). Arbitrates with round-robin priority, drives the ROM's CE/OCE/AD/RESET pins, and tracks in-flight lookups through the ROM latency. Each result is returned to its originating port with a range flag. Sits between the packet-to-frame-buffer logic, the LCD scan-out logic and the Gowin pROM instance.

## Interface
Parameters:
- IDX_W, 10, index width (ROM address).
- ADDR_W, 12, returned DDR address width (ROM data).
- LIMIT_INDEX, 680, first index whose table entry is the saturation value 0xFF0.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush; drops in-flight lookups.
- p0_req_valid / p1_req_valid  in  1  lookup request.
- p0_req_ready / p1_req_ready  out  1  request accepted this cycle.
- p0_req_index / p1_req_index  in  IDX_W  index to translate.
- p0_resp_valid / p1_resp_valid  out  1  one-cycle result strobe.
- p0_resp_addr / p1_resp_addr  out  ADDR_W  translated DDR address.
- p0_resp_oor / p1_resp_oor  out  1  index ≥ LIMIT_INDEX (address is saturated).
- rom_ad  out  IDX_W  ROM address.
- rom_ce  out  1  ROM clock enable.
- rom_oce  out  1  ROM output clock enable; tied high.
- rom_reset  out  1  ROM synchronous reset, active-high.
- rom_dout  in  ADDR_W  ROM read data.

## Operation
- Arbitration happens each cycle in which any req_valid is high and clear is low. Exactly one port is granted.
  - Single requester: that port is granted.
  - Both requesting: the port not granted last time wins. The last-grant pointer resets to port 1, so port 0 wins the first tie.
- req_ready is high only for the granted port. A handshake is req_valid && req_ready. The responses have no back-pressure, so throughput is one lookup per cycle.
- Accept: register rom_ad ← index and rom_ce ← 1. Push the tag {port, oor} into the pipeline stage.
- oor = (index ≥ LIMIT_INDEX), computed combinationally at accept.
- When no handshake occurs, rom_ce = 0 and rom_ad holds its last value.
- Result: the tag is delayed to align with rom_dout. rom_dout is captured into the granted port's resp_addr, and that port's resp_valid is pulsed. The other port's resp_valid stays 0.
- resp_addr holds its value between strobes.
- clear: zeroes all tag valid bits and rom_ce in the same cycle, and forces req_ready = 0. Lookups already accepted produce no response. The pointer is unchanged.
- rom_reset: high while reset_n is low, and for exactly one cycle after deassertion (synchronised release). req_ready is 0 during that cycle.

## Timing
- Handshake in cycle N → rom_ce = 1 and rom_ad valid in N+1 → rom_dout valid in N+2 → resp_valid and resp_addr registered, visible in N+3. Fixed latency: 3 cycles.
- Back-to-back accepts in N and N+1 give responses in N+3 and N+4, in order, each tagged to its own port.
- Reset values:
  - all req_ready = 0, all resp_valid = 0, resp_addr = 0, resp_oor = 0;
  - rom_ce = 0, rom_ad = 0, rom_reset = 1, rom_oce = 1;
  - pipeline tags invalid.
- Reset asserted mid-flight: all pending lookups are discarded asynchronously. No resp_valid appears after release.
- clear in cycle N with an accept in N−1 or N−2: no response is produced for those accepts. A new accept is possible in N+1.
- Simultaneous response strobe and new request on the same port is legal and independent.

## Structure
- Package index_lookup_pkg: IDX_W, ADDR_W, LIMIT_INDEX, SAT_ADDR = 12'hFF0, and a tag struct {valid, port, oor}.
- One sub-module, index_lookup_rr2: two-way round-robin arbiter (req[1:0], accept, grant[1:0], last-grant pointer).
- The top level holds the ROM drive registers, the 2-stage tag pipeline and the response registers.
- The Gowin pROM is instantiated outside this block.

## Test plan
- Reset release, p0 index 5 → rom_reset high until 1 cycle after release; p0_resp_valid 3 cycles after handshake with addr 0x01E, oor = 0.
- p0 and p1 valid together continuously, p0 index 1, p1 index 2 → grants alternate p0, p1, p0…; responses 0x006 on p0 and 0x00C on p1, one per cycle, in order.
- p1 index 0x2A7, then 0x2A8 → addr 0xFEA with oor = 0, then 0xFF0 with oor = 1.
- Accept p0 index 16; assert clear 1 cycle later → no resp_valid on either port; next request, index 32, returns 0x0C0.
- Assert reset_n low 1 cycle after accept → no response after release; all outputs at reset values.
- Random back-to-back traffic on both ports against a model of index×6 saturating at 0xFF0 → every response matches, with correct port and order.
